// File: rtl/fma16_pkg.sv
// fma16_pkg: shared types and helpers for the fp16 multiply-accumulate
// command front-end.
//   op_e     - 3-bit command opcode
//   rm_e     - 2-bit roundmode as presented to the datapath
//   ctrl_t   - datapath control bundle {mul, add, negr, negz}
//   decode_op - opcode to control bundle
//   FP16_ZERO / FP16_ONE - commonly used fp16 constants
package fma16_pkg;

    typedef enum logic [2:0] {
        OP_FADD   = 3'b000,
        OP_FSUB   = 3'b001,
        OP_FMUL   = 3'b010,
        OP_FMADD  = 3'b011,
        OP_FMSUB  = 3'b100,
        OP_FNMADD = 3'b101,
        OP_FNMSUB = 3'b110,
        OP_FMACC  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RP  = 2'b10,
        RM_RN  = 2'b11
    } rm_e;

    typedef struct packed {
        logic mul;
        logic add;
        logic negr;
        logic negz;
    } ctrl_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    // fmacc shares the fmadd controls; only its z source differs.
    function automatic ctrl_t decode_op(input op_e op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_FADD:   c = 4'b0100;
            OP_FSUB:   c = 4'b0101;
            OP_FMUL:   c = 4'b1000;
            OP_FMADD:  c = 4'b1100;
            OP_FMSUB:  c = 4'b1101;
            OP_FNMADD: c = 4'b1110;
            OP_FNMSUB: c = 4'b1111;
            OP_FMACC:  c = 4'b1100;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fma16_issue_rspq.sv
// fma16_rspq: DEPTH-entry synchronous FIFO of {tag, data} responses.
//   clk, reset_n        - clock, asynchronous active-low reset
//   push, push_tag/data - write side (caller guarantees not full)
//   pop                 - read side (caller guarantees not empty)
//   out_valid/tag/data  - head entry, held stable until popped
//   count               - number of stored entries
module fma16_rspq
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [3:0]                 push_tag,
    input  logic [15:0]                push_data,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [3:0]                 out_tag,
    output logic [15:0]                out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads as zero when empty.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_tag, push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign {out_tag, out_data} = mem[rd_ptr];

endmodule

// File: rtl/fma16_issue.sv
// fma16_issue: command front-end and result collector for the fp16 FMA
// datapath.
//   cmd_*            - opcode/operand command stream (valid/ready)
//   acc_clr          - zero the running accumulator
//   fma_*            - registered operands and controls to the datapath
//   fma_result       - datapath result, sampled LAT cycles after issue
//   rsp_*            - tagged results in issue order (valid/ready)
//   acc              - running accumulator (last captured result)
module fma16_issue
    import fma16_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_rm,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [15:0] cmd_z,
    input  logic [3:0]  cmd_tag,
    input  logic        acc_clr,
    output logic [15:0] fma_x,
    output logic [15:0] fma_y,
    output logic [15:0] fma_z,
    output logic        fma_mul,
    output logic        fma_add,
    output logic        fma_negr,
    output logic        fma_negz,
    output logic [1:0]  fma_rm,
    input  logic [15:0] fma_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_tag,
    output logic [15:0] acc
);

    localparam int CW = $clog2(DEPTH) + 1;

    ctrl_t          ctrl;
    logic           is_macc;
    logic           issue;
    logic           capture;
    logic           pop;
    logic [LAT-1:0] tok_valid;
    logic [3:0]     tok_tag [LAT];
    logic [15:0]    inflight;
    logic [CW-1:0]  count;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + 16'(tok_valid[i]);
    end

    assign ctrl    = decode_op(op_e'(cmd_op));
    assign is_macc = (cmd_op == OP_FMACC);

    // Credits cover both queued and in-flight results, so a capture can
    // never find the FIFO full. fmacc waits for an idle pipe so it reads
    // an accumulator that already holds the previous result.
    assign cmd_ready = ((inflight + 16'(count)) < 16'(DEPTH)) &&
                       !(is_macc && (inflight != '0));
    assign issue     = cmd_valid && cmd_ready;
    assign capture   = tok_valid[LAT-1];
    assign pop       = rsp_valid && rsp_ready;

    // Operand registers hold their value between issues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fma_x    <= '0;
            fma_y    <= '0;
            fma_z    <= '0;
            fma_mul  <= 1'b0;
            fma_add  <= 1'b0;
            fma_negr <= 1'b0;
            fma_negz <= 1'b0;
            fma_rm   <= '0;
        end else if (issue) begin
            fma_x    <= cmd_x;
            fma_y    <= cmd_y;
            fma_z    <= is_macc ? (acc_clr ? FP16_ZERO : acc) : cmd_z;
            fma_mul  <= ctrl.mul;
            fma_add  <= ctrl.add;
            fma_negr <= ctrl.negr;
            fma_negz <= ctrl.negz;
            fma_rm   <= cmd_rm;
        end
    end

    // Valid/tag token pipe whose exit marks the result sampling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tok_valid <= '0;
            for (int i = 0; i < LAT; i++) tok_tag[i] <= '0;
        end else begin
            tok_valid[0] <= issue;
            tok_tag[0]   <= cmd_tag;
            for (int i = 1; i < LAT; i++) begin
                tok_valid[i] <= tok_valid[i-1];
                tok_tag[i]   <= tok_tag[i-1];
            end
        end
    end

    // A clear wins over a result landing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     acc <= FP16_ZERO;
        else if (acc_clr) acc <= FP16_ZERO;
        else if (capture) acc <= fma_result;
    end

    fma16_rspq #(.DEPTH(DEPTH)) u_rspq (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (capture),
        .push_tag  (tok_tag[LAT-1]),
        .push_data (fma_result),
        .pop       (pop),
        .out_valid (rsp_valid),
        .out_tag   (rsp_tag),
        .out_data  (rsp_data),
        .count     (count)
    );

endmodule
